sd_sector_buffer: RTL
=====================

# sd_sector_buffer

Assembles one 512-byte SD card data block, received a byte at a time from the SPI read engine, into a flat 4096-bit sector register. Sits directly upstream of the halfword read divider, which indexes `sector_data` 16 bits at a time. Flags completion, timeout and, optionally, CRC mismatch to the storage controller FSM.

## Interface
- `TIMEOUT_CYCLES`, default 65535: number of consecutive FILL/CRC cycles without an accepted byte that aborts the sector.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a new sector; honoured only in IDLE.
- `byte_in`  in  8  data byte from the SPI engine, MSB received first.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  block accepts a byte this cycle; a byte transfers when `byte_valid && byte_ready`.
- `busy`  out  1  high in FILL, CRC and DONE.
- `sector_data`  out  4096  assembled sector.
- `sector_valid`  out  1  level; `sector_data` holds a complete sector.
- `sector_done`  out  1  one-cycle pulse on completion.
- `crc_err`  out  1  registered CRC mismatch result for the last sector.
- `timeout`  out  1  one-cycle pulse on abort.

## Operation
- States: IDLE, FILL, CRC (only with the macro), DONE.
- IDLE: `byte_ready`=0. `start` moves the FSM to FILL and clears `byte_cnt` (10 bit), the idle counter, `sector_valid`, `crc_err` and the CRC register. `byte_valid` is ignored in IDLE.
- FILL: `byte_ready`=1. Each accepted byte n (n = `byte_cnt`, 0..511) writes bit b (7 = MSB) to `sector_data[8n + (7-b)]`.
  - So halfword k = {byte 2k, byte 2k+1} occupies bits 16k..16k+15, MSB at the lowest index. This is the layout the downstream divider expects.
  - On acceptance of byte 511: go to CRC when the macro is defined, otherwise go to DONE.
- CRC: `byte_ready`=1. Accepts exactly 2 bytes, the received CRC high byte then low byte, into a 16-bit register. After the second byte, go to DONE.
- DONE: lasts one cycle. `sector_done`=1. `sector_valid` set to 1 and held until the next accepted `start` or `rst`. Then return to IDLE.
- `sector_data` is never cleared; unwritten bytes keep stale contents, and `sector_valid` alone qualifies the data.
- `start` in FILL, CRC or DONE is ignored.
- Timeout:
  - The idle counter increments on every FILL/CRC cycle with no accepted byte and clears on any accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE and `timeout` pulses for one cycle.
  - `sector_valid` stays 0 and `sector_done` does not fire.
- `rst` at any time, including mid-fill: FSM to IDLE, all outputs 0 except `sector_data` (holds); a partial sector is discarded.

## Timing
- Reset values: `byte_ready`=0, `busy`=0, `sector_valid`=0, `sector_done`=0, `crc_err`=0, `timeout`=0; `sector_data` undefined until written.
- `start` sampled at edge t: `byte_ready`=1 from cycle t+1.
- A byte accepted at edge t is visible in `sector_data` from cycle t+1.
- Final byte accepted at edge t (byte 511, or the CRC low byte with the macro): `sector_done`=1, `sector_valid`=1 and `crc_err` final, all in cycle t+1. `byte_ready`=0 in t+1. IDLE at t+2.
- Back-to-back: `start` is accepted earliest in cycle t+2.
- Throughput: one byte per cycle maximum; `byte_valid` may idle arbitrarily below `TIMEOUT_CYCLES`.
- Timeout: last acceptance at edge t, then no further bytes. `timeout` is high in cycle t+`TIMEOUT_CYCLES`+1, with the FSM in IDLE in that same cycle.

## Configuration
- `SD_SECTOR_CRC_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 0x0000, MSB first) is computed over the 512 data bytes, updating one byte per accepted byte.
  - The CRC state is entered, and 514 bytes are consumed per sector.
  - `crc_err` = (computed != received) in the DONE cycle, held until the next `start` or `rst`.
- `SD_SECTOR_CRC_EN` undefined: no CRC state and no CRC logic; 512 bytes are consumed per sector and `crc_err` is tied to 0.

## Test plan
- Fill order: `start`, then bytes n = 0..511 with value n mod 256 every cycle. Required: halfword 0 (bits 0..15, MSB at bit 0) = 0x0001; halfword 255 = 0xFEFF; `sector_done` exactly 1 cycle after the final acceptance; `sector_valid` held high.
- CRC pass (macro on): 512 × 0xFF followed by 0x7F, 0xA1 -> `crc_err`=0. Same sector followed by 0x7F, 0xA0 -> `crc_err`=1, `sector_done`=1.
- Throttled input: `byte_valid` toggling 1/0/0 with random gaps shorter than `TIMEOUT_CYCLES` -> identical `sector_data` to the full-rate run, no `timeout`.
- Timeout: `TIMEOUT_CYCLES`=16, stop after 100 bytes -> `timeout` pulses 17 cycles after the last acceptance; `sector_valid`=0; a new `start` then completes a full sector normally.
- Reset mid-fill: assert `rst` after byte 300 -> next cycle `busy`=0, `byte_ready`=0, `sector_valid`=0. A fresh `start` plus 512 bytes yields a correct sector with `byte_cnt` restarted at 0.
- Ignored inputs: `byte_valid`=1 in IDLE (no change to `sector_data`), and `start` asserted at byte 200 (fill continues, done after byte 511) -> each handled as specified.

Source files
------------

// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: assembles one 512-byte SD data block, delivered a byte at a time by the SPI
// read engine, into a flat 4096-bit sector register. The downstream halfword divider reads it
// 16 bits at a time.
//
// Layout: byte n, bit b (7 = MSB) lands at sector_data[8n + (7-b)], so halfword k =
// {byte 2k, byte 2k+1} occupies bits 16k..16k+15 with its MSB at the lowest index.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           begin a new sector (honoured only when idle)
//   byte_in         data byte, MSB received first
//   byte_valid      byte_in valid; transfers when byte_valid && byte_ready
//   byte_ready      block accepts a byte this cycle
//   busy            sector in progress (fill, crc or done cycle)
//   sector_data     assembled sector; never cleared, qualified by sector_valid
//   sector_valid    level, sector_data holds a complete sector
//   sector_done     one-cycle completion pulse
//   crc_err         CRC mismatch for the last sector (0 when CRC checking is not built)
//   timeout         one-cycle pulse when a sector is aborted for lack of bytes
//
// Build option: define SD_SECTOR_CRC_EN to also consume the 2-byte CRC-16-CCITT trailer and
// check it against the CRC computed over the 512 data bytes.
module sd_sector_buffer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          busy,
  output logic [4095:0] sector_data,
  output logic          sector_valid,
  output logic          sector_done,
  output logic          crc_err,
  output logic          timeout
);

  // Idle count at which the next byte-less cycle aborts the sector.
  localparam logic [31:0] IdleLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
`ifdef SD_SECTOR_CRC_EN
    , StCrc = 2'd3
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     idle_q, idle_d;
  logic            sector_valid_q, sector_valid_d;
  logic            timeout_q, timeout_d;
  logic [4095:0]   sector_q;
  logic [7:0]      byte_rev;
  logic            accept;

`ifdef SD_SECTOR_CRC_EN
  logic [15:0] crc_calc_q, crc_calc_d;
  logic [15:0] crc_rx_q, crc_rx_d;
  logic        crc_err_q, crc_err_d;

  // CRC-16-CCITT (poly 0x1021), one byte, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign byte_ready = (state_q == StFill) || (state_q == StCrc);
  assign crc_err    = crc_err_q;
`else
  assign byte_ready = (state_q == StFill);
  assign crc_err    = 1'b0;
`endif

  assign accept       = byte_valid && byte_ready;
  assign busy         = (state_q != StIdle);
  assign sector_done  = (state_q == StDone);
  assign sector_valid = sector_valid_q;
  assign timeout      = timeout_q;
  assign sector_data  = sector_q;

  // MSB of the byte goes to the lowest bit index of its slot.
  assign byte_rev = {<<{byte_in}};

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    idle_d         = idle_q;
    sector_valid_d = sector_valid_q;
    timeout_d      = 1'b0;
`ifdef SD_SECTOR_CRC_EN
    crc_calc_d     = crc_calc_q;
    crc_rx_d       = crc_rx_q;
    crc_err_d      = crc_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d        = StFill;
          byte_cnt_d     = '0;
          idle_d         = '0;
          sector_valid_d = 1'b0;
`ifdef SD_SECTOR_CRC_EN
          crc_calc_d     = '0;
          crc_rx_d       = '0;
          crc_err_d      = 1'b0;
`endif
        end
      end
      StFill: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
          idle_d     = '0;
`ifdef SD_SECTOR_CRC_EN
          crc_calc_d = crc16_byte(crc_calc_q, byte_in);
          if (byte_cnt_q == 10'd511) state_d = StCrc;
`else
          if (byte_cnt_q == 10'd511) begin
            state_d        = StDone;
            sector_valid_d = 1'b1;
          end
`endif
        end
      end
`ifdef SD_SECTOR_CRC_EN
      StCrc: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
          idle_d     = '0;
          crc_rx_d   = {crc_rx_q[7:0], byte_in};
          if (byte_cnt_q == 10'd513) begin
            state_d        = StDone;
            sector_valid_d = 1'b1;
            crc_err_d      = (crc_calc_q != crc_rx_d);
          end
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Byte-less cycle while receiving: count towards the abort.
    if (byte_ready && !accept) begin
      idle_d = idle_q + 32'd1;
      if (idle_q == IdleLast) begin
        state_d   = StIdle;
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      byte_cnt_q     <= '0;
      idle_q         <= '0;
      sector_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      idle_q         <= idle_d;
      sector_valid_q <= sector_valid_d;
      timeout_q      <= timeout_d;
    end
  end

`ifdef SD_SECTOR_CRC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_calc_q <= '0;
      crc_rx_q   <= '0;
      crc_err_q  <= 1'b0;
    end else begin
      crc_calc_q <= crc_calc_d;
      crc_rx_q   <= crc_rx_d;
      crc_err_q  <= crc_err_d;
    end
  end
`endif

  // Sector storage has no reset: stale bytes survive rst and aborts.
  always_ff @(posedge clk) begin
    if (!rst && accept && (state_q == StFill)) begin
      sector_q[{byte_cnt_q[8:0], 3'b000} +: 8] <= byte_rev;
    end
  end

endmodule
